// File: rtl/mac_skew_feeder.sv
// rtl/mac_skew_feeder.sv - per-lane operand FIFOs streamed diagonally (skewed) into a row of MACs
// Define MAC_FEEDER_OVF_ERR_EN to add the sticky err output for dropped writes and ignored starts.
module mac_skew_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int DEPTH      = 8,
  localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [LW-1:0]                 wr_lane,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          clr_out,
  output logic [LANES-1:0]              en_out,
  output logic [LANES*DATA_WIDTH-1:0]   a_out
`ifdef MAC_FEEDER_OVF_ERR_EN
  ,
  output logic                          err
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + LANES);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);
  localparam logic [SW-1:0] C_LAST  = SW'(DEPTH + LANES - 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]                  r_state;
  logic [1:0]                  w_state_nxt;
  logic [SW-1:0]               r_c;
  logic [SW-1:0]               w_c_nxt;
  logic [CW-1:0]               r_cnt [LANES];
  logic [DATA_WIDTH-1:0]       r_mem [LANES][DEPTH];
  logic                        w_idle;
  logic                        w_wr_ok;
  logic                        w_all_full;
  logic                        w_start_ok;
  logic [LANES-1:0]            w_en_nxt;
  logic [LANES*DATA_WIDTH-1:0] w_a_nxt;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_clr;
  logic [LANES-1:0]            r_en;
  logic [LANES*DATA_WIDTH-1:0] r_a;

  assign w_idle  = (r_state == S_IDLE);
  assign w_wr_ok = w_idle && wr_en && (int'(wr_lane) < LANES) && (r_cnt[wr_lane] != FULL);

  // Occupancy is judged after this cycle's write so a final write plus start launches together.
  always_comb begin
    w_all_full = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (!((r_cnt[i] == FULL) ||
            ((r_cnt[i] == FULL_M1) && w_wr_ok && (int'(wr_lane) == i)))) begin
        w_all_full = 1'b0;
      end
    end
  end

  assign w_start_ok = w_idle && start && w_all_full;

  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        w_state_nxt = S_STREAM;
        w_c_nxt     = '0;
      end
      S_STREAM: begin
        if (r_c == C_LAST) w_state_nxt = S_DONE;
        else               w_c_nxt     = r_c + SW'(1);
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_c_nxt     = '0;
      end
    endcase
  end

  // Outputs are precomputed from the next state so every output leaves a flop.
  always_comb begin
    w_en_nxt = '0;
    w_a_nxt  = '0;
    if (w_state_nxt == S_STREAM) begin
      for (int i = 0; i < LANES; i++) begin
        if ((int'(w_c_nxt) >= i) && (int'(w_c_nxt) < i + DEPTH)) begin
          w_en_nxt[i] = 1'b1;
          w_a_nxt[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[i][IW'(int'(w_c_nxt) - i)];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clr   <= 1'b0;
      r_en    <= '0;
      r_a     <= '0;
      for (int i = 0; i < LANES; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      r_clr   <= (w_state_nxt == S_CLEAR);
      r_en    <= w_en_nxt;
      r_a     <= w_a_nxt;
      for (int i = 0; i < LANES; i++) begin
        if (r_state == S_DONE)                        r_cnt[i] <= '0;
        else if (w_wr_ok && (int'(wr_lane) == i))     r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[wr_lane][r_cnt[wr_lane][IW-1:0]] <= wr_data;
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign clr_out = r_clr;
  assign en_out  = r_en;
  assign a_out   = r_a;

`ifdef MAC_FEEDER_OVF_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                            r_err <= 1'b0;
    else if ((wr_en && !w_wr_ok) || (start && !w_start_ok)) r_err <= 1'b1;
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_mac_skew_feeder.sv
// tb/tb_mac_skew_feeder.sv - randomized bench with a timeline model of mac_skew_feeder and MAC sum checks
// Honours MAC_FEEDER_OVF_ERR_EN for the err output.
module tb_mac_skew_feeder;
  localparam int DW = 8;
  localparam int L  = 8;
  localparam int D  = 8;
  localparam int N  = D + L - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_lane = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          clr_out;
  logic [L-1:0]  en_out;
  logic [L*DW-1:0] a_out;
`ifdef MAC_FEEDER_OVF_ERR_EN
  logic          err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mac_skew_feeder #(.DATA_WIDTH(DW), .LANES(L), .DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_lane (wr_lane),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .clr_out (clr_out),
    .en_out  (en_out),
    .a_out   (a_out)
`ifdef MAC_FEEDER_OVF_ERR_EN
    ,
    .err     (err)
`endif
  );

  // m_rel: -1 idle, otherwise edges since the accepted start (0 clear, 1..N stream, N+1 done)
  logic [DW-1:0] q [L][$];
  logic [DW-1:0] snap [L][D];
  int            m_rel = -1;
  logic          m_err = 1'b0;
  int            acc [L];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rel = -1;
      m_err = 1'b0;
      for (int i = 0; i < L; i++) q[i].delete();
    end else if (m_rel < 0) begin
      bit full_all;
      if (wr_en) begin
        if (q[wr_lane].size() < D) q[wr_lane].push_back(wr_data);
        else                       m_err = 1'b1;
      end
      full_all = 1'b1;
      for (int i = 0; i < L; i++) if (q[i].size() != D) full_all = 1'b0;
      if (start && full_all) begin
        for (int i = 0; i < L; i++) begin
          for (int k = 0; k < D; k++) snap[i][k] = q[i][k];
          q[i].delete();
        end
        m_rel = 0;
      end else if (start) begin
        m_err = 1'b1;
      end
    end else begin
      if (wr_en || start) m_err = 1'b1;
      m_rel++;
      if (m_rel > N + 1) m_rel = -1;
    end
  end

  always @(negedge clk) begin
    logic [L-1:0]    e_en;
    logic [L*DW-1:0] e_a;
    int              c;
    int              sum;
    e_en = '0;
    e_a  = '0;
    if (m_rel >= 1 && m_rel <= N) begin
      c = m_rel - 1;
      for (int i = 0; i < L; i++) begin
        if (c >= i && c < i + D) begin
          e_en[i] = 1'b1;
          e_a[i*DW +: DW] = snap[i][c-i];
        end
      end
    end
    chk("busy", busy, m_rel >= 0);
    chk("done", done, m_rel == N + 1);
    chk("clr_out", clr_out, m_rel == 0);
    chk("en_out", en_out, e_en);
    chk("a_out", a_out, e_a);
`ifdef MAC_FEEDER_OVF_ERR_EN
    chk("err", err, m_err);
`endif
    if (m_rel == N + 1) begin
      for (int i = 0; i < L; i++) begin
        sum = 0;
        for (int k = 0; k < D; k++) sum += int'(snap[i][k]);
        chk($sformatf("mac_cout_lane%0d", i), acc[i], sum);
      end
    end
    // MAC row with B=1: clear on clr_out, accumulate a_out while enabled
    for (int i = 0; i < L; i++) begin
      if (clr_out)        acc[i] = 0;
      else if (en_out[i]) acc[i] += int'(a_out[i*DW +: DW]);
    end
  end

  task automatic drive(input logic w, input int lane, input logic [DW-1:0] d, input logic s);
    @(negedge clk);
    wr_en   = w;
    wr_lane = lane[2:0];
    wr_data = d;
    start   = s;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, '0, 1'b0);
  endtask

  task automatic load_seq();
    for (int i = 0; i < L; i++)
      for (int k = 0; k < D; k++) drive(1'b1, i, DW'(8 * i + k + 1), 1'b0);
  endtask

  task automatic run_pinned();
    load_seq();
    drive(1'b0, 0, '0, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      drive(1'b0, 0, '0, 1'b0);
      if (k == 1)  chk("pin_clr_at_1", clr_out, 1);
      if (k == 2)  begin chk("pin_en_c0", en_out, 8'h01); chk("pin_a0_c0", a_out[7:0], 1); end
      if (k == 9)  begin
        chk("pin_en_c7", en_out, 8'hFF);
        chk("pin_a7_c7", a_out[63:56], 57);
        chk("pin_a0_c7", a_out[7:0], 8);
      end
      if (k == 16) chk("pin_en_c14", en_out, 8'h80);
      if (k == 17) chk("pin_done_at_17", done, 1);
      if (k == 18) chk("pin_idle_after", busy, 0);
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < L; i++) if (q[i].size() != D) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_clr", clr_out, 0);
    chk("rst_en", en_out, 0);
    chk("rst_a", a_out, 0);
    rst_n = 1'b1;

    run_pinned();

    // partial load: start must be ignored; final write and start share a cycle
    for (int i = 0; i < 7; i++)
      for (int k = 0; k < D; k++) drive(1'b1, i, DW'($urandom), 1'b0);
    drive(1'b0, 0, '0, 1'b1);
    repeat (3) begin
      drive(1'b0, 0, '0, 1'b0);
      chk("partial_busy", busy, 0);
      chk("partial_clr", clr_out, 0);
    end
    for (int k = 0; k < D - 1; k++) drive(1'b1, 7, DW'($urandom), 1'b0);
    drive(1'b1, 7, DW'($urandom), 1'b1);
    idle(20);

    // ninth write to lane 3 dropped
    load_seq();
    drive(1'b1, 3, 8'hEE, 1'b0);
    drive(1'b0, 0, '0, 1'b1);
    idle(20);

    // start and a write at c=4 ignored
    load_seq();
    drive(1'b0, 0, '0, 1'b1);
    for (int k = 1; k <= 19; k++) drive(k == 6, 2, 8'h55, k == 6);

    // reset at c=5 aborts, then a clean rerun
    load_seq();
    drive(1'b0, 0, '0, 1'b1);
    repeat (7) drive(1'b0, 0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_en", en_out, 0);
    chk("abort_a", a_out, 0);
    chk("abort_done", done, 0);
    idle(2);
    rst_n = 1'b1;
    run_pinned();

    for (int it = 0; it < 12; it++) begin
      for (int n = 0; n < 400 && !model_full(); n++)
        drive(1'b1, $urandom_range(0, L - 1), DW'($urandom), $urandom_range(0, 15) == 0);
      repeat ($urandom_range(0, 2)) drive(1'b1, $urandom_range(0, L - 1), DW'($urandom), 1'b0);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, L - 1), DW'($urandom), 1'b1);
      repeat (20) drive($urandom_range(0, 3) == 0, $urandom_range(0, L - 1), DW'($urandom),
                        $urandom_range(0, 7) == 0);
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
